if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/if_id_reg.sv | 28 ++
 rtl/if_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: machine width, canonical NOP and the IF/ID payload.
// Also holds the fetch-action encoding used by the IF stage priority logic.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};

    // One action per rising edge, listed lowest to highest priority.
    typedef enum logic [1:0] {
        ACT_FETCH    = 2'd0,
        ACT_WAIT     = 2'd1,
        ACT_HOLD     = 2'd2,
        ACT_REDIRECT = 2'd3
    } fetch_action_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble overrides load, otherwise the contents hold.
// Reset and bubble both produce the canonical NOP with valid cleared.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= IF_ID_BUBBLE;
        end else if (bubble) begin
            q_r <= IF_ID_BUBBLE;
        end else if (load) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect/stall/wait priority and IF/ID handoff.
// Define IF_STAGE_PERF_CNT_EN to build the flush/stall performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            flush,
    output logic [XLEN-1:0] perf_flush_cnt,
    output logic [XLEN-1:0] perf_stall_cnt
);
    import riscv_pkg::*;

    // Memory handshake: imem_addr is presented for the whole cycle; imem_rdata is
    // consumed on a rising edge only when imem_ready=1 there, otherwise the PC is
    // held and the same address is presented again. There is no request strobe.

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;
    fetch_action_e   action;
    if_id_t          if_id_d;
    if_id_t          if_id_q;
    logic            if_id_load;
    logic            if_id_bubble;

    always_comb begin
        if (branch_taken) begin
            action = ACT_REDIRECT;
        end else if (stall) begin
            action = ACT_HOLD;
        end else if (!imem_ready) begin
            action = ACT_WAIT;
        end else begin
            action = ACT_FETCH;
        end
    end

    // Natural wrap modulo 2^32 at the top of the address space.
    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        pc_next = pc_q;
        case (action)
            ACT_REDIRECT: pc_next = word_align(branch_target);
            ACT_FETCH:    pc_next = pc_plus4;
            default:      pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_next;
        end
    end

    assign imem_addr = pc_q;

    assign if_id_d      = '{pc: pc_q, instr: imem_rdata, valid: 1'b1};
    assign if_id_load   = (action == ACT_FETCH);
    assign if_id_bubble = (action == ACT_REDIRECT) || (action == ACT_WAIT);

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (if_id_load),
        .bubble (if_id_bubble),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign if_id_pc    = if_id_q.pc;
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;

    // Not gated by reset so the downstream squash tracks EX even while IF is held.
    assign flush = branch_taken;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [XLEN-1:0] flush_cnt_q;
    logic [XLEN-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (branch_taken) begin
                flush_cnt_q <= flush_cnt_q + XLEN'(1);
            end
            if (action == ACT_HOLD) begin
                stall_cnt_q <= stall_cnt_q + XLEN'(1);
            end
        end
    end

    assign perf_flush_cnt = flush_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_flush_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
